cpu_prog_feeder: RTL
====================

# cpu_prog_feeder

Program sequencer that drives the instruction/data input of the simple 16-bit `cpu`, which has a `DIN`/`Run`/`Done` interface. The feeder does the following:

- Holds a small program memory loaded over a write port.
- On start, issues each 9-bit instruction word (`III XXX YYY` in bits [8:0]) to the cpu with `Run`.
- Supplies the immediate word in the following cycle for `mvi`.
- Waits for `Done` before advancing.

It replaces hand-timed stimulus in front of the cpu and is the producer end of the cpu's `DIN` handshake.

## Interface
- `ADDR_W`, 5: program memory address width; depth = 2**ADDR_W words.
- `IMM_OP`, 3'b001: opcode (bits [8:6]) whose instruction is followed by one immediate word.
- `TIMEOUT`, 16: maximum cycles to wait for `iDone` after issue before aborting.
- `iClk` in 1: clock. One clock; all logic on rising edge.
- `iRst` in 1: reset, asynchronous, active-high.
- `iWe` in 1: program memory write strobe; honoured only in IDLE.
- `iWaddr` in `ADDR_W`: write address.
- `iWdata` in 16: write data.
- `iStart` in 1: start program; sampled in IDLE only.
- `iLen` in `ADDR_W`+1: program length in words, counting immediates; latched on start.
- `iDone` in 1: cpu `Done`.
- `oDin` out 16: to cpu `DIN`; registered.
- `oRun` out 1: to cpu `Run`; registered.
- `oBusy` out 1: high in any state other than IDLE.
- `oFinish` out 1: one-cycle pulse when the last instruction completes.
- `oErr` out 1: sticky error; cleared by next accepted `iStart` or reset.
- `oPc` out `ADDR_W`+1: current program word index.

## Operation
- States: IDLE, ISSUE, IMM, WAIT.
- **Reset:** state IDLE; `oDin`=0, `oRun`=0, `oBusy`=0, `oFinish`=0, `oErr`=0, `oPc`=0. Memory contents are not reset.
- **IDLE:**
  - `iWe` writes `mem[iWaddr]`.
  - `iStart` with `iLen`≠0: latch length, `oPc`<=0, `oDin`<=`mem[0]`, clear `oErr`, go ISSUE.
  - `iStart` with `iLen`=0: pulse `oFinish`, stay IDLE.
  - When `iWe` and `iStart` occur in the same cycle, the write occurs and the start reads the pre-write memory.
- **ISSUE** (exactly one cycle):
  - `oRun`=1; `oDin` = instruction.
  - If `oDin[8:6]`==`IMM_OP`:
    - If `oPc`+1 ≥ length: truncated program; set `oErr`, go IDLE.
    - Otherwise `oDin`<=`mem[oPc+1]`, go IMM.
  - Otherwise go WAIT, with `oDin` held.
  - `iDone` is ignored in ISSUE.
- **IMM** (one cycle): `oRun`=0; `oDin` = immediate. If `iDone`, advance by 2; else go WAIT.
- **WAIT:** `oRun`=0; `oDin` held. On `iDone`, advance by n, where n = 2 if the current instruction is `IMM_OP`, else 1.
- **Advance:** new pc = `oPc`+n.
  - If new pc ≥ length: `oFinish` pulse, `oPc`<=new pc, go IDLE with `oDin`<=0.
  - Otherwise `oPc`<=new pc, `oDin`<=`mem[new pc]`, go ISSUE.
- **Timeout:** a counter clears on entry to ISSUE and increments in IMM/WAIT. Reaching `TIMEOUT` without `iDone` sets `oErr`, `oDin`<=0, and goes IDLE; `oPc` holds the failing index.
- `iStart` while busy is ignored. `iWe` while busy is ignored; memory is unchanged.
- Bits [15:9] of each word are forwarded unchanged; the feeder decodes only [8:6].
- **Reset mid-program:** immediate return to reset values; the cpu must be reset alongside.

## Timing
- Start to first `oRun`=1: one cycle after the `iStart` edge.
- 1-word instruction whose cpu `Done` arrives in the first post-issue cycle: ISSUE, WAIT(done), ISSUE, giving 2 cycles per instruction.
- `mvi` with `Done` during the immediate cycle: ISSUE, IMM(done), ISSUE, giving 2 cycles.
- A 4-cycle ALU op gives 4 cycles per instruction.
- `oFinish` is asserted in the cycle after the final `iDone` is sampled; `oBusy` falls in that same cycle.
- `oRun` is never high in two consecutive cycles.

## Test plan
- **Load/run mvi:** load `mem[0]`=0x0040 (mvi R0), `mem[1]`=0x000A, `iLen`=2; model cpu raises `Done` during IMM.
  - Required: `oDin` 0x0040 with `oRun`=1, then 0x000A with `oRun`=0, then `oFinish` pulse.
  - Total 3 cycles from start to `oFinish`.
- **Mixed program:** mvi R1,0x0008; mv R7,R0 (0x0038); add R0,R1 (0x0081); `iLen`=4; model Done latencies 2/2/4.
  - Required: `oPc` sequence 0,2,3,4; `oFinish` once; `oErr`=0.
- **Truncated immediate:** `iLen`=1, `mem[0]`=0x0048.
  - Required: one ISSUE cycle, then `oErr`=1, `oBusy`=0, no `oFinish`.
- **Timeout:** `iLen`=1, `mem[0]`=0x0038, `iDone` held 0.
  - Required: `oErr` rises exactly `TIMEOUT` cycles after the WAIT entry cycle; `oPc`=0.
  - A subsequent `iStart` clears `oErr`.
- **Busy protection:** during a run, pulse `iStart` and `iWe` (`mem[0]`<=0xFFFF).
  - Required: run unaffected; after finish, `mem[0]` is still its original value.
- **Reset mid-WAIT:** assert `iRst` asynchronously between clock edges.
  - Required: all outputs return to 0 immediately, without waiting for a clock edge; state IDLE.

Source files
------------

// File: rtl/cpu_prog_feeder.sv
// cpu_prog_feeder: program sequencer feeding instruction/immediate words to the cpu DIN/Run/Done port.
module cpu_prog_feeder #(
  parameter int         ADDR_W  = 5,
  parameter logic [2:0] IMM_OP  = 3'b001,
  parameter int         TIMEOUT = 16
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iWe,
  input  logic [ADDR_W-1:0] iWaddr,
  input  logic [15:0]       iWdata,
  input  logic              iStart,
  input  logic [ADDR_W:0]   iLen,
  input  logic              iDone,
  output logic [15:0]       oDin,
  output logic              oRun,
  output logic              oBusy,
  output logic              oFinish,
  output logic              oErr,
  output logic [ADDR_W:0]   oPc
);
  typedef enum logic [1:0] {IDLE, ISSUE, IMM, WAIT} state_t;
  state_t            r_state, w_state;
  logic [15:0]       r_mem [2**ADDR_W];
  logic [15:0]       r_din, w_din;
  logic [ADDR_W:0]   r_pc, w_pc, r_len, w_len;
  logic [15:0]       r_cnt, w_cnt;
  logic              r_run, r_fin, w_fin, r_err, w_err, r_imm, w_imm;
  logic [ADDR_W+1:0] w_nxt, w_adv;
  assign w_nxt = {1'b0, r_pc} + (ADDR_W+2)'(1);
  assign w_adv = {1'b0, r_pc} + (r_imm ? (ADDR_W+2)'(2) : (ADDR_W+2)'(1));
  // Memory is writable only while idle; the start path reads the pre-write contents.
  always_ff @(posedge iClk)
    if (iWe && r_state == IDLE) r_mem[iWaddr] <= iWdata;
  always_comb begin
    w_state = r_state;
    w_din   = r_din;
    w_pc    = r_pc;
    w_len   = r_len;
    w_cnt   = r_cnt;
    w_err   = r_err;
    w_imm   = r_imm;
    w_fin   = 1'b0;
    case (r_state)
      IDLE:
        if (iStart) begin
          if (iLen != '0) begin
            w_len   = iLen;
            w_pc    = '0;
            w_din   = r_mem[0];
            w_err   = 1'b0;
            w_state = ISSUE;
          end else w_fin = 1'b1;
        end
      ISSUE: begin
        w_cnt = '0;
        w_imm = r_din[8:6] == IMM_OP;
        if (!w_imm) w_state = WAIT;
        else if (w_nxt >= {1'b0, r_len}) begin
          w_err   = 1'b1;
          w_din   = '0;
          w_state = IDLE;
        end else begin
          w_din   = r_mem[w_nxt[ADDR_W-1:0]];
          w_state = IMM;
        end
      end
      IMM, WAIT:
        if (iDone) begin
          w_pc = w_adv[ADDR_W:0];
          if (w_adv >= {1'b0, r_len}) begin
            w_fin   = 1'b1;
            w_din   = '0;
            w_state = IDLE;
          end else begin
            w_din   = r_mem[w_adv[ADDR_W-1:0]];
            w_state = ISSUE;
          end
        end else if (r_cnt == 16'(TIMEOUT - 1)) begin
          w_err   = 1'b1;
          w_din   = '0;
          w_state = IDLE;
        end else w_cnt = r_cnt + 16'd1;
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge iClk or posedge iRst)
    if (iRst) begin
      r_state <= IDLE;
      r_din   <= '0;
      r_pc    <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_run   <= 1'b0;
      r_fin   <= 1'b0;
      r_err   <= 1'b0;
      r_imm   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_din   <= w_din;
      r_pc    <= w_pc;
      r_len   <= w_len;
      r_cnt   <= w_cnt;
      r_run   <= w_state == ISSUE;
      r_fin   <= w_fin;
      r_err   <= w_err;
      r_imm   <= w_imm;
    end
  assign oDin    = r_din;
  assign oRun    = r_run;
  assign oBusy   = r_state != IDLE;
  assign oFinish = r_fin;
  assign oErr    = r_err;
  assign oPc     = r_pc;
endmodule
